// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline types: result-source encodings and the E-stage control bundle.
// The all-zero control constant is what a bubble carries into execute.
package pipe_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic [2:0] alucontrol;
        logic       alusrc;
        logic       jalrctrl;
    } ctrl_e_t;

    localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in E whose destination is read by the instruction in D.
// Latency: combinational.
// Backpressure: none; the caller decides whether the flag becomes a stall.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int A_WIDTH = 5
) (
    input  logic               i_valid_e,
    input  logic [1:0]         i_resultsrc_e,
    input  logic [A_WIDTH-1:0] i_rd_e,
    input  logic [A_WIDTH-1:0] i_rs1_d,
    input  logic [A_WIDTH-1:0] i_rs2_d,
    output logic               o_lduse
);

    logic w_is_load;
    logic w_rd_live;
    logic w_match;

    assign w_is_load = i_valid_e && (i_resultsrc_e == RES_MEM);
    // x0 is never really written, so a load into it cannot create a hazard.
    assign w_rd_live = (i_rd_e != '0);
    assign w_match   = (i_rd_e == i_rs1_d) || (i_rd_e == i_rs2_d);
    assign o_lduse   = w_is_load && w_rd_live && w_match;

endmodule

// File: rtl/decode_execute_reg.sv
// ID/EX register with load-use bubble insertion, branch flush and hold; IDEX_PERF_EN adds a bubble counter.
// Latency: 1 cycle D->E; lduse_stall_o is combinational.
// Backpressure: hold_i freezes E and masks flush/stall; lduse_stall_o stalls F and D.
module decode_execute_reg
    import pipe_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold_i,
    input  logic               pcsrc_e_i,
    input  logic               valid_d_i,
    input  logic               regwrite_d_i,
    input  logic               memwrite_d_i,
    input  logic               alusrc_d_i,
    input  logic               jalrctrl_d_i,
    input  logic [1:0]         resultsrc_d_i,
    input  logic [2:0]         alucontrol_d_i,
    input  logic [D_WIDTH-1:0] rd1_d_i,
    input  logic [D_WIDTH-1:0] rd2_d_i,
    input  logic [D_WIDTH-1:0] pc_d_i,
    input  logic [D_WIDTH-1:0] pcplus4_d_i,
    input  logic [D_WIDTH-1:0] immext_d_i,
    input  logic [A_WIDTH-1:0] rs1_d_i,
    input  logic [A_WIDTH-1:0] rs2_d_i,
    input  logic [A_WIDTH-1:0] rd_d_i,
    output logic               regwrite_e_o,
    output logic               memwrite_e_o,
    output logic               alusrc_e_o,
    output logic               jalrctrl_e_o,
    output logic [1:0]         resultsrc_e_o,
    output logic [2:0]         alucontrol_e_o,
    output logic [D_WIDTH-1:0] rd1_e_o,
    output logic [D_WIDTH-1:0] rd2_e_o,
    output logic [D_WIDTH-1:0] pc_e_o,
    output logic [D_WIDTH-1:0] pcplus4_e_o,
    output logic [D_WIDTH-1:0] immext_e_o,
    output logic [A_WIDTH-1:0] rs1_e_o,
    output logic [A_WIDTH-1:0] rs2_e_o,
    output logic [A_WIDTH-1:0] rd_e_o,
    output logic               valid_e_o,
    output logic               lduse_stall_o
`ifdef IDEX_PERF_EN
    ,
    output logic [31:0]        bubble_cnt_o
`endif
);

    ctrl_e_t              r_ctrl;
    logic [D_WIDTH-1:0]   r_rd1;
    logic [D_WIDTH-1:0]   r_rd2;
    logic [D_WIDTH-1:0]   r_pc;
    logic [D_WIDTH-1:0]   r_pcplus4;
    logic [D_WIDTH-1:0]   r_immext;
    logic [A_WIDTH-1:0]   r_rs1;
    logic [A_WIDTH-1:0]   r_rs2;
    logic [A_WIDTH-1:0]   r_rd;
    logic                 r_valid;

    ctrl_e_t              w_ctrl_d;
    logic                 w_lduse;
    logic                 w_bubble;

    load_use_detect #(
        .A_WIDTH (A_WIDTH)
    ) u_load_use_detect (
        .i_valid_e     (r_valid),
        .i_resultsrc_e (r_ctrl.resultsrc),
        .i_rd_e        (r_rd),
        .i_rs1_d       (rs1_d_i),
        .i_rs2_d       (rs2_d_i),
        .o_lduse       (w_lduse)
    );

    // A non-valid D slot must not carry side effects into E.
    always_comb begin
        w_ctrl_d = CTRL_BUBBLE;
        if (valid_d_i) begin
            w_ctrl_d.regwrite   = regwrite_d_i;
            w_ctrl_d.resultsrc  = resultsrc_d_i;
            w_ctrl_d.memwrite   = memwrite_d_i;
            w_ctrl_d.alucontrol = alucontrol_d_i;
            w_ctrl_d.alusrc     = alusrc_d_i;
            w_ctrl_d.jalrctrl   = jalrctrl_d_i;
        end
    end

    assign w_bubble      = pcsrc_e_i || w_lduse;
    assign lduse_stall_o = w_lduse && !hold_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl    <= CTRL_BUBBLE;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_pc      <= '0;
            r_pcplus4 <= '0;
            r_immext  <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_valid   <= 1'b0;
        end else if (!hold_i) begin
            if (w_bubble) begin
                r_ctrl    <= CTRL_BUBBLE;
                r_rd1     <= '0;
                r_rd2     <= '0;
                r_pc      <= '0;
                r_pcplus4 <= '0;
                r_immext  <= '0;
                r_rs1     <= '0;
                r_rs2     <= '0;
                r_rd      <= '0;
                r_valid   <= 1'b0;
            end else begin
                r_ctrl    <= w_ctrl_d;
                r_rd1     <= rd1_d_i;
                r_rd2     <= rd2_d_i;
                r_pc      <= pc_d_i;
                r_pcplus4 <= pcplus4_d_i;
                r_immext  <= immext_d_i;
                r_rs1     <= rs1_d_i;
                r_rs2     <= rs2_d_i;
                r_rd      <= rd_d_i;
                r_valid   <= valid_d_i;
            end
        end
    end

`ifdef IDEX_PERF_EN
    logic [31:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (!hold_i && w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
`endif

    assign regwrite_e_o   = r_ctrl.regwrite;
    assign memwrite_e_o   = r_ctrl.memwrite;
    assign alusrc_e_o     = r_ctrl.alusrc;
    assign jalrctrl_e_o   = r_ctrl.jalrctrl;
    assign resultsrc_e_o  = r_ctrl.resultsrc;
    assign alucontrol_e_o = r_ctrl.alucontrol;
    assign rd1_e_o        = r_rd1;
    assign rd2_e_o        = r_rd2;
    assign pc_e_o         = r_pc;
    assign pcplus4_e_o    = r_pcplus4;
    assign immext_e_o     = r_immext;
    assign rs1_e_o        = r_rs1;
    assign rs2_e_o        = r_rs2;
    assign rd_e_o         = r_rd;
    assign valid_e_o      = r_valid;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Directed bench for decode_execute_reg: reset, capture, load-use, flush, hold priority, async reset.
// Optional bubble-counter checks are built when IDEX_PERF_EN is defined.
module tb_decode_execute_reg;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hold_i = 1'b0;
    logic          pcsrc_e_i = 1'b0;
    logic          valid_d_i = 1'b0;
    logic          regwrite_d_i = 1'b0;
    logic          memwrite_d_i = 1'b0;
    logic          alusrc_d_i = 1'b0;
    logic          jalrctrl_d_i = 1'b0;
    logic [1:0]    resultsrc_d_i = '0;
    logic [2:0]    alucontrol_d_i = '0;
    logic [DW-1:0] rd1_d_i = '0, rd2_d_i = '0, pc_d_i = '0, pcplus4_d_i = '0, immext_d_i = '0;
    logic [AW-1:0] rs1_d_i = '0, rs2_d_i = '0, rd_d_i = '0;

    logic          regwrite_e_o, memwrite_e_o, alusrc_e_o, jalrctrl_e_o;
    logic [1:0]    resultsrc_e_o;
    logic [2:0]    alucontrol_e_o;
    logic [DW-1:0] rd1_e_o, rd2_e_o, pc_e_o, pcplus4_e_o, immext_e_o;
    logic [AW-1:0] rs1_e_o, rs2_e_o, rd_e_o;
    logic          valid_e_o, lduse_stall_o;
`ifdef IDEX_PERF_EN
    logic [31:0]   bubble_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    decode_execute_reg #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .hold_i         (hold_i),
        .pcsrc_e_i      (pcsrc_e_i),
        .valid_d_i      (valid_d_i),
        .regwrite_d_i   (regwrite_d_i),
        .memwrite_d_i   (memwrite_d_i),
        .alusrc_d_i     (alusrc_d_i),
        .jalrctrl_d_i   (jalrctrl_d_i),
        .resultsrc_d_i  (resultsrc_d_i),
        .alucontrol_d_i (alucontrol_d_i),
        .rd1_d_i        (rd1_d_i),
        .rd2_d_i        (rd2_d_i),
        .pc_d_i         (pc_d_i),
        .pcplus4_d_i    (pcplus4_d_i),
        .immext_d_i     (immext_d_i),
        .rs1_d_i        (rs1_d_i),
        .rs2_d_i        (rs2_d_i),
        .rd_d_i         (rd_d_i),
        .regwrite_e_o   (regwrite_e_o),
        .memwrite_e_o   (memwrite_e_o),
        .alusrc_e_o     (alusrc_e_o),
        .jalrctrl_e_o   (jalrctrl_e_o),
        .resultsrc_e_o  (resultsrc_e_o),
        .alucontrol_e_o (alucontrol_e_o),
        .rd1_e_o        (rd1_e_o),
        .rd2_e_o        (rd2_e_o),
        .pc_e_o         (pc_e_o),
        .pcplus4_e_o    (pcplus4_e_o),
        .immext_e_o     (immext_e_o),
        .rs1_e_o        (rs1_e_o),
        .rs2_e_o        (rs2_e_o),
        .rd_e_o         (rd_e_o),
        .valid_e_o      (valid_e_o),
        .lduse_stall_o  (lduse_stall_o)
`ifdef IDEX_PERF_EN
        ,
        .bubble_cnt_o   (bubble_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_d(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                           input logic [2:0] alu, input logic asrc, input logic jalr,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d);
        valid_d_i = v;   regwrite_d_i = rw; resultsrc_d_i = rs; memwrite_d_i = mw;
        alucontrol_d_i = alu; alusrc_d_i = asrc; jalrctrl_d_i = jalr;
        rd1_d_i = r1; rd2_d_i = r2; pc_d_i = pc; pcplus4_d_i = pc + 32'd4; immext_d_i = imm;
        rs1_d_i = s1; rs2_d_i = s2; rd_d_i = d;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, {31'd0, valid_e_o}, 32'd0);
        chk({tag, ".regwrite"}, {31'd0, regwrite_e_o}, 32'd0);
        chk({tag, ".memwrite"}, {31'd0, memwrite_e_o}, 32'd0);
        chk({tag, ".resultsrc"}, {30'd0, resultsrc_e_o}, 32'd0);
        chk({tag, ".rd"}, {27'd0, rd_e_o}, 32'd0);
        chk({tag, ".rs1"}, {27'd0, rs1_e_o}, 32'd0);
        chk({tag, ".rs2"}, {27'd0, rs2_e_o}, 32'd0);
        chk({tag, ".rd1"}, rd1_e_o, 32'd0);
        chk({tag, ".pc"}, pc_e_o, 32'd0);
        chk({tag, ".imm"}, immext_e_o, 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        chk_bubble("reset");
        chk("reset.stall", {31'd0, lduse_stall_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // add x3,x1,x2
        drive_d(1, 1, 2'b00, 0, 3'b000, 0, 0, 32'd7, 32'd9, 32'h100, 32'd0, 5'd1, 5'd2, 5'd3);
        edge_step();
        chk("add.rd1", rd1_e_o, 32'd7);
        chk("add.rd2", rd2_e_o, 32'd9);
        chk("add.rd", {27'd0, rd_e_o}, 32'd3);
        chk("add.regwrite", {31'd0, regwrite_e_o}, 32'd1);
        chk("add.valid", {31'd0, valid_e_o}, 32'd1);
        chk("add.pc4", pcplus4_e_o, 32'h104);
        chk("add.rs2", {27'd0, rs2_e_o}, 32'd2);

        // lw x5 then dependent add x6,x5,x2
        drive_d(1, 1, 2'b01, 0, 3'b000, 1, 0, 32'h40, 32'd0, 32'h104, 32'd4, 5'd1, 5'd0, 5'd5);
        edge_step();
        chk("lw.resultsrc", {30'd0, resultsrc_e_o}, 32'd1);
        drive_d(1, 1, 2'b00, 0, 3'b000, 0, 0, 32'd11, 32'd2, 32'h108, 32'd0, 5'd5, 5'd2, 5'd6);
        #1;
        chk("lduse.stall", {31'd0, lduse_stall_o}, 32'd1);
        edge_step();
        chk_bubble("lduse.bubble");
        chk("lduse.stall_after", {31'd0, lduse_stall_o}, 32'd0);
        edge_step();
        chk("lduse.resume.rd", {27'd0, rd_e_o}, 32'd6);
        chk("lduse.resume.rd1", rd1_e_o, 32'd11);
        chk("lduse.resume.valid", {31'd0, valid_e_o}, 32'd1);

        // Load into x0 never stalls
        drive_d(1, 1, 2'b01, 0, 3'b000, 1, 0, 32'h50, 32'd0, 32'h10c, 32'd8, 5'd1, 5'd0, 5'd0);
        edge_step();
        drive_d(1, 1, 2'b00, 0, 3'b000, 0, 0, 32'h22, 32'd0, 32'h110, 32'd0, 5'd0, 5'd0, 5'd7);
        #1;
        chk("x0.stall", {31'd0, lduse_stall_o}, 32'd0);
        edge_step();
        chk("x0.rd", {27'd0, rd_e_o}, 32'd7);
        chk("x0.rd1", rd1_e_o, 32'h22);

        // Flush kills a valid sw
        drive_d(1, 0, 2'b00, 1, 3'b000, 1, 0, 32'h55, 32'h66, 32'h114, 32'd12, 5'd2, 5'd3, 5'd10);
        pcsrc_e_i = 1'b1;
        edge_step();
        pcsrc_e_i = 1'b0;
        chk_bubble("flush");
        chk("flush.rd2", rd2_e_o, 32'd0);

        // Non-valid D: control suppressed, data still captured
        drive_d(0, 1, 2'b01, 1, 3'b101, 1, 1, 32'h33, 32'h44, 32'h118, 32'd0, 5'd4, 5'd4, 5'd9);
        edge_step();
        chk("inv.regwrite", {31'd0, regwrite_e_o}, 32'd0);
        chk("inv.memwrite", {31'd0, memwrite_e_o}, 32'd0);
        chk("inv.alucontrol", {29'd0, alucontrol_e_o}, 32'd0);
        chk("inv.valid", {31'd0, valid_e_o}, 32'd0);
        chk("inv.rd", {27'd0, rd_e_o}, 32'd9);
        chk("inv.rd1", rd1_e_o, 32'h33);

        // Hold beats flush and load-use
        drive_d(1, 1, 2'b01, 0, 3'b010, 1, 0, 32'h80, 32'd0, 32'h11c, 32'd16, 5'd1, 5'd0, 5'd5);
        edge_step();
        drive_d(1, 1, 2'b00, 0, 3'b000, 0, 0, 32'h77, 32'd0, 32'h120, 32'd0, 5'd5, 5'd0, 5'd8);
        hold_i = 1'b1;
        pcsrc_e_i = 1'b1;
        #1;
        chk("hold.stall0", {31'd0, lduse_stall_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            edge_step();
            chk("hold.rd", {27'd0, rd_e_o}, 32'd5);
            chk("hold.valid", {31'd0, valid_e_o}, 32'd1);
            chk("hold.rd1", rd1_e_o, 32'h80);
            chk("hold.stall", {31'd0, lduse_stall_o}, 32'd0);
        end
        hold_i = 1'b0;
        #1;
        chk("release.stall", {31'd0, lduse_stall_o}, 32'd1);
        edge_step();
        pcsrc_e_i = 1'b0;
        chk_bubble("release");
        edge_step();
        chk("after_release.rd", {27'd0, rd_e_o}, 32'd8);
        chk("after_release.rd1", rd1_e_o, 32'h77);
`ifdef IDEX_PERF_EN
        chk("perf.count", bubble_cnt_o, 32'd3);
`endif

        // Asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        chk("arst.regwrite", {31'd0, regwrite_e_o}, 32'd0);
        chk("arst.rd", {27'd0, rd_e_o}, 32'd0);
        chk("arst.valid", {31'd0, valid_e_o}, 32'd0);
        chk("arst.rd1", rd1_e_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        edge_step();
        chk("post_arst.rd", {27'd0, rd_e_o}, 32'd8);

`ifdef IDEX_PERF_EN
        chk("perf.reset", bubble_cnt_o, 32'd0);
        @(negedge clk);
        force dut.r_bubble_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_bubble_cnt;
        pcsrc_e_i = 1'b1;
        for (int i = 0; i < 3; i++) edge_step();
        pcsrc_e_i = 1'b0;
        chk("perf.saturate", bubble_cnt_o, 32'hFFFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
